prvp_spi_slave_rx_mlane: RTL and testbench
==========================================

Name: prvp_spi_slave_rx_mlane

Overview:
Parametrised multi-lane SPI slave receive deserializer. Generalises the single/quad fixed-32-bit receiver: configurable word width and lane count (1/2/4/8), bit order and per-word length, plus a small output FIFO with valid/ready handshake and overflow detection. Runs entirely in the SPI serial-clock domain. Feeds the slave command/data decoder; any CDC is handled downstream.

Parameters:
DATA_WIDTH, 32, maximum word width in bits (multiple of 8).
MAX_LANES, 4, number of sdi lanes physically present (1, 2, 4 or 8).
CNT_WIDTH, 8, width of the beat counter and length inputs.
FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).
MSB_FIRST, 1, 1 = first received bit lands in the MSB of the word; 0 = LSB first.

Ports:
clk  input  1  SPI serial clock; all state is updated on its rising edge.
rstnn  input  1  asynchronous active-low reset.
frame_active  input  1  chip select asserted (already inverted), sampled on each clk edge.
sdi  input  MAX_LANES  serial data lanes; sdi[0] is the single-lane line.
lane_mode  input  2  0=1 lane, 1=2, 2=4, 3=8; values above MAX_LANES clamp to MAX_LANES.
len_in  input  CNT_WIDTH  beats-minus-one for subsequent words.
len_upd  input  1  load len_in as pending word length.
word_data  output  DATA_WIDTH  FIFO head word.
word_valid  output  1  FIFO not empty.
word_ready  input  1  consumer accepts head word.
fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
overflow_clr  input  1  clears overflow.
partial_drop  output  1  one-cycle pulse: frame ended with a word partly received.
busy  output  1  beat counter nonzero (word in progress).

Behaviour:
- Reset (rstnn=0, async): beat counter 0, shift register 0, target = command default, FIFO empty, word_valid=0, word_data=0, fifo_count=0, overflow=0, partial_drop=0, busy=0.
- Beat = any clk edge with frame_active=1. Edge with frame_active=0: beat counter, shift register and target return to reset values; FIFO and overflow are kept; partial_drop=1 for that cycle if beat counter was nonzero.
- L = clamped lane count, latched at the first beat of each word and held until the word completes.
- Command default: first word of every frame is 8 bits, target = 8/L − 1 beats-minus-one (L=8: 0).
- len_upd (honoured only when frame_active=1) writes a pending target, clipped to DATA_WIDTH/L − 1 using the L in force when the pending target becomes active. Pending becomes active at the next word start; a len_upd on the same edge as a word completion applies to the following word. With no new len_upd, subsequent words reuse the last active target (the command default only for the first word).
- Shift: MSB_FIRST=1: sr <= {sr, sdi[L-1:0]} with sdi[L-1] most significant; the word is right-aligned, with zero upper bits. MSB_FIRST=0: sr[beat*L +: L] <= sdi[L-1:0].
- Completion: on the beat where counter == target, the assembled word (including this beat's lanes) is pushed into the FIFO; the counter returns to 0 and sr is cleared. word_valid is high after that same edge (latency 0 edges after the last beat).
- FIFO: pop on word_valid & word_ready. Push while full drops the word and sets overflow, unless a pop occurs on the same edge, in which case the push is accepted. Simultaneous overflow set and overflow_clr: set wins. Pop when empty has no effect.
- word_data holds its value while word_valid=1 and word_ready=0.

Test Plan:
- Single lane, MSB_FIRST=1: frame sends 0xA5 -> after 8th edge word_data=0x000000A5, word_valid=1, fifo_count=1.
- Quad lanes: cmd 2 beats (0xB,0xC), then len_upd len_in=7, 8 beats 0x1..0x8 -> words 0xBC, 0x12345678.
- MSB_FIRST=0, dual lanes, 0b01,0b10,0b11,0b00 -> word 0x39.
- word_ready=0, five 8-bit words with FIFO_DEPTH=4 -> fifo_count=4, 5th dropped, overflow=1; overflow_clr on the same edge as a new drop -> overflow stays 1.
- frame_active drops after 3 of 8 beats -> partial_drop pulse, no push, next frame's first word uses the command default.
- rstnn low mid-word with 2 words queued -> word_valid=0, fifo_count=0 immediately (async).

Source files
------------

// File: rtl/prvp_spi_slave_rx_mlane.sv
// rtl/prvp_spi_slave_rx_mlane.sv - multi-lane SPI slave receive deserializer with output FIFO
module prvp_spi_slave_rx_mlane #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LANES  = 4,
   parameter int CNT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rstnn,
   input  logic                        frame_active,
   input  logic [MAX_LANES-1:0]        sdi,
   input  logic [1:0]                  lane_mode,
   input  logic [CNT_WIDTH-1:0]        len_in,
   input  logic                        len_upd,
   output logic [DATA_WIDTH-1:0]       word_data,
   output logic                        word_valid,
   input  logic                        word_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        overflow_clr,
   output logic                        partial_drop,
   output logic                        busy
);

   localparam int LOG_MAX = $clog2(MAX_LANES);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   logic [CNT_WIDTH-1:0]  cnt, tgt, pend;
   logic                  pend_valid, first_word;
   logic [1:0]            l_log;
   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;

   logic [1:0]            mode_log, cur_log;
   logic [3:0]            lanes;
   logic                  word_start, done, pop, full, push, drop;
   logic [CNT_WIDTH-1:0]  cmd_tgt, max_tgt, start_tgt, cur_tgt;
   logic [DATA_WIDTH-1:0] din, sr_next;

   assign word_valid = (fifo_count != '0);
   assign word_data  = word_valid ? mem[rd_ptr] : '0;
   assign busy       = (cnt != '0);

   always_comb begin
      mode_log   = (int'(lane_mode) > LOG_MAX) ? 2'(LOG_MAX) : lane_mode;
      word_start = (cnt == '0);
      // lane count is taken live on the first beat, then held for the rest of the word
      cur_log    = word_start ? mode_log : l_log;
      lanes      = 4'd1 << cur_log;
      cmd_tgt    = CNT_WIDTH'((8 >> cur_log) - 1);
      max_tgt    = CNT_WIDTH'((DATA_WIDTH >> cur_log) - 1);
      if (first_word)
         start_tgt = cmd_tgt;
      else if (pend_valid)
         start_tgt = (pend > max_tgt) ? max_tgt : pend;
      else
         start_tgt = tgt;
      cur_tgt    = word_start ? start_tgt : tgt;
      din        = DATA_WIDTH'(sdi) & ((DATA_WIDTH'(1) << lanes) - DATA_WIDTH'(1));
      if (MSB_FIRST)
         sr_next = (sr << lanes) | din;
      else
         sr_next = sr | (din << (int'(cnt) * int'(lanes)));
      done       = frame_active && (cnt == cur_tgt);
      pop        = word_valid && word_ready;
      full       = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
      push       = done && (!full || pop);
      drop       = done && full && !pop;
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         cnt          <= '0;
         tgt          <= '0;
         pend         <= '0;
         pend_valid   <= 1'b0;
         first_word   <= 1'b1;
         l_log        <= '0;
         sr           <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         overflow     <= 1'b0;
         partial_drop <= 1'b0;
      end else begin
         partial_drop <= 1'b0;
         if (!frame_active) begin
            cnt          <= '0;
            sr           <= '0;
            tgt          <= '0;
            l_log        <= '0;
            pend_valid   <= 1'b0;
            first_word   <= 1'b1;
            partial_drop <= (cnt != '0);
         end else begin
            if (word_start) begin
               l_log      <= mode_log;
               tgt        <= start_tgt;
               first_word <= 1'b0;
               if (!first_word)
                  pend_valid <= 1'b0;
            end
            if (done) begin
               cnt <= '0;
               sr  <= '0;
            end else begin
               cnt <= cnt + CNT_WIDTH'(1);
               sr  <= sr_next;
            end
            // a length written on a completion edge stays pending for the following word
            if (len_upd) begin
               pend       <= len_in;
               pend_valid <= 1'b1;
            end
         end
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= sr_next;
   end

endmodule

// File: tb/tb_prvp_spi_slave_rx_mlane.sv
// tb/tb_prvp_spi_slave_rx_mlane.sv - self-checking bench for prvp_spi_slave_rx_mlane
module tb_prvp_spi_slave_rx_mlane;

   localparam int DW = 32;
   localparam int ML = 4;
   localparam int CW = 8;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rstnn = 1'b0;
   logic          frame_active = 1'b0;
   logic [ML-1:0] sdi = '0;
   logic [1:0]    lane_mode = '0;
   logic [CW-1:0] len_in = '0;
   logic          len_upd = 1'b0;
   logic          word_ready = 1'b0;
   logic          overflow_clr = 1'b0;

   logic [DW-1:0] word_data_m, word_data_l;
   logic          word_valid_m, word_valid_l;
   logic [2:0]    fifo_count_m, fifo_count_l;
   logic          overflow_m, overflow_l;
   logic          partial_drop_m, partial_drop_l;
   logic          busy_m, busy_l;

   int total = 0;
   int bad = 0;
   logic [31:0] qm[$];
   logic [31:0] ql[$];
   logic        exp_ovf = 1'b0;

   prvp_spi_slave_rx_mlane #(.DATA_WIDTH(DW), .MAX_LANES(ML), .CNT_WIDTH(CW),
                             .FIFO_DEPTH(FD), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rstnn(rstnn), .frame_active(frame_active), .sdi(sdi),
      .lane_mode(lane_mode), .len_in(len_in), .len_upd(len_upd),
      .word_data(word_data_m), .word_valid(word_valid_m), .word_ready(word_ready),
      .fifo_count(fifo_count_m), .overflow(overflow_m), .overflow_clr(overflow_clr),
      .partial_drop(partial_drop_m), .busy(busy_m));

   prvp_spi_slave_rx_mlane #(.DATA_WIDTH(DW), .MAX_LANES(ML), .CNT_WIDTH(CW),
                             .FIFO_DEPTH(FD), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rstnn(rstnn), .frame_active(frame_active), .sdi(sdi),
      .lane_mode(lane_mode), .len_in(len_in), .len_upd(len_upd),
      .word_data(word_data_l), .word_valid(word_valid_l), .word_ready(word_ready),
      .fifo_count(fifo_count_l), .overflow(overflow_l), .overflow_clr(overflow_clr),
      .partial_drop(partial_drop_l), .busy(busy_l));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lanes_of(input int lm);
      int l = 1 << lm;
      return (l > ML) ? ML : l;
   endfunction

   function automatic logic [31:0] lane_mask(input int l);
      return (32'd1 << l) - 32'd1;
   endfunction

   // Word seen by an LSB-first receiver given the beats of an MSB-first word w.
   function automatic logic [31:0] lsb_of(input int l, input int n, input logic [31:0] w);
      logic [31:0] r = '0;
      logic [31:0] b;
      for (int i = 0; i < n; i++) begin
         b = (w >> ((n - 1 - i) * l)) & lane_mask(l);
         r = r | (b << (i * l));
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_word(input int bits);
      logic [31:0] w = $urandom;
      if (bits < 32) w = w & ((32'd1 << bits) - 32'd1);
      return w;
   endfunction

   task automatic send_word(input int lm, input int n, input logic [31:0] w,
                            input bit upd, input logic [7:0] ulen);
      int l = lanes_of(lm);
      logic [31:0] wl = lsb_of(l, n, w);
      logic [31:0] beat;
      for (int i = 0; i < n; i++) begin
         frame_active = 1'b1;
         lane_mode = 2'(lm);
         beat = (w >> ((n - 1 - i) * l)) & lane_mask(l);
         sdi = 4'(beat | (32'($urandom) << l));
         len_upd = upd && (i == n - 1);
         len_in = ulen;
         tick();
         if (i < n - 1) begin
            total++;
            if (busy_m !== 1'b1) begin
               bad++;
               $display("FAIL busy_mid beat=%0d got=%b exp=1", i, busy_m);
            end
         end
      end
      len_upd = 1'b0;
      if (word_ready) begin
         qm = {w};
         ql = {wl};
      end else if (qm.size() < FD) begin
         qm.push_back(w);
         ql.push_back(wl);
      end else begin
         exp_ovf = 1'b1;
      end
      total++;
      if (word_valid_m !== 1'b1 || word_valid_l !== 1'b1) begin
         bad++;
         $display("FAIL word_valid got=%b/%b exp=1", word_valid_m, word_valid_l);
      end
      total++;
      if (word_data_m !== qm[0]) begin
         bad++;
         $display("FAIL word_data_msb got=%h exp=%h", word_data_m, qm[0]);
      end
      total++;
      if (word_data_l !== ql[0]) begin
         bad++;
         $display("FAIL word_data_lsb got=%h exp=%h", word_data_l, ql[0]);
      end
      total++;
      if (fifo_count_m !== 3'(qm.size()) || fifo_count_l !== 3'(qm.size())) begin
         bad++;
         $display("FAIL fifo_count got=%0d/%0d exp=%0d", fifo_count_m, fifo_count_l, qm.size());
      end
      total++;
      if (overflow_m !== exp_ovf || busy_m !== 1'b0) begin
         bad++;
         $display("FAIL ovf_busy got=%b,%b exp=%b,0", overflow_m, busy_m, exp_ovf);
      end
   endtask

   task automatic test_reset();
      rstnn = 1'b0;
      tick();
      tick();
      total++;
      if (word_valid_m !== 1'b0 || word_data_m !== 32'h0 || fifo_count_m !== 3'd0) begin
         bad++;
         $display("FAIL reset_fifo got=%b,%h,%0d exp=0,0,0", word_valid_m, word_data_m, fifo_count_m);
      end
      total++;
      if (overflow_m !== 1'b0 || partial_drop_m !== 1'b0 || busy_m !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b,%b,%b exp=0,0,0", overflow_m, partial_drop_m, busy_m);
      end
      rstnn = 1'b1;
      tick();
      total++;
      if (word_valid_l !== 1'b0 || fifo_count_l !== 3'd0 || busy_l !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got=%b,%0d,%b exp=0,0,0", word_valid_l, fifo_count_l, busy_l);
      end
   endtask

   task automatic test_single_lane();
      word_ready = 1'b1;
      send_word(0, 8, 32'hA5, 1'b0, 8'd0);
      total++;
      if (word_data_m !== 32'h0000_00A5) begin
         bad++;
         $display("FAIL single_a5 got=%h exp=000000a5", word_data_m);
      end
      frame_active = 1'b0;
      tick();
      total++;
      if (partial_drop_m !== 1'b0) begin
         bad++;
         $display("FAIL single_nodrop got=%b exp=0", partial_drop_m);
      end
   endtask

   task automatic test_quad();
      send_word(2, 2, 32'hBC, 1'b1, 8'd7);
      send_word(2, 8, 32'h1234_5678, 1'b0, 8'd0);
      total++;
      if (word_data_m !== 32'h1234_5678) begin
         bad++;
         $display("FAIL quad_word got=%h exp=12345678", word_data_m);
      end
      frame_active = 1'b0;
      tick();
   endtask

   task automatic test_lsb_dual();
      send_word(1, 4, 32'h6C, 1'b0, 8'd0);
      total++;
      if (word_data_l !== 32'h39) begin
         bad++;
         $display("FAIL lsb_dual got=%h exp=00000039", word_data_l);
      end
      frame_active = 1'b0;
      tick();
   endtask

   task automatic test_partial();
      send_word(0, 8, rand_word(8), 1'b1, 8'd31);
      for (int i = 0; i < 3; i++) begin
         sdi = 4'($urandom);
         tick();
      end
      total++;
      if (busy_m !== 1'b1 || word_valid_m !== 1'b0) begin
         bad++;
         $display("FAIL partial_busy got=%b,%b exp=1,0", busy_m, word_valid_m);
      end
      frame_active = 1'b0;
      tick();
      total++;
      if (partial_drop_m !== 1'b1 || partial_drop_l !== 1'b1 || busy_m !== 1'b0 || word_valid_m !== 1'b0) begin
         bad++;
         $display("FAIL partial_pulse got=%b%b,%b,%b exp=11,0,0", partial_drop_m, partial_drop_l, busy_m, word_valid_m);
      end
      tick();
      total++;
      if (partial_drop_m !== 1'b0) begin
         bad++;
         $display("FAIL partial_one_cycle got=%b exp=0", partial_drop_m);
      end
      send_word(0, 8, rand_word(8), 1'b0, 8'd0);
      frame_active = 1'b0;
      tick();
   endtask

   task automatic test_overflow();
      logic [31:0] w;
      tick();
      word_ready = 1'b0;
      qm.delete();
      ql.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i < 5; i++)
         send_word(2, 2, rand_word(8), 1'b0, 8'd0);
      overflow_clr = 1'b1;
      send_word(2, 2, rand_word(8), 1'b0, 8'd0);
      frame_active = 1'b0;
      tick();
      overflow_clr = 1'b0;
      exp_ovf = 1'b0;
      total++;
      if (overflow_m !== 1'b0 || fifo_count_m !== 3'd4) begin
         bad++;
         $display("FAIL ovf_clear got=%b,%0d exp=0,4", overflow_m, fifo_count_m);
      end
      w = rand_word(8);
      frame_active = 1'b1;
      lane_mode = 2'd2;
      sdi = 4'(w >> 4);
      tick();
      sdi = 4'(w);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      frame_active = 1'b0;
      void'(qm.pop_front());
      void'(ql.pop_front());
      qm.push_back(w);
      ql.push_back(lsb_of(4, 2, w));
      total++;
      if (fifo_count_m !== 3'd4 || overflow_m !== 1'b0 || word_data_m !== qm[0]) begin
         bad++;
         $display("FAIL full_pop_push got=%0d,%b,%h exp=4,0,%h", fifo_count_m, overflow_m, word_data_m, qm[0]);
      end
      word_ready = 1'b1;
      for (int i = 0; i < FD; i++) begin
         total++;
         if (word_data_m !== qm[0] || word_data_l !== ql[0]) begin
            bad++;
            $display("FAIL drain_%0d got=%h/%h exp=%h/%h", i, word_data_m, word_data_l, qm[0], ql[0]);
         end
         tick();
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      total++;
      if (word_valid_m !== 1'b0 || fifo_count_m !== 3'd0) begin
         bad++;
         $display("FAIL drain_empty got=%b,%0d exp=0,0", word_valid_m, fifo_count_m);
      end
   endtask

   task automatic test_reset_mid();
      word_ready = 1'b0;
      qm.delete();
      ql.delete();
      send_word(0, 8, rand_word(8), 1'b0, 8'd0);
      send_word(0, 8, rand_word(8), 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) begin
         sdi = 4'($urandom);
         tick();
      end
      #2;
      rstnn = 1'b0;
      #1;
      total++;
      if (word_valid_m !== 1'b0 || fifo_count_m !== 3'd0 || busy_m !== 1'b0 || word_data_m !== 32'h0) begin
         bad++;
         $display("FAIL async_reset got=%b,%0d,%b,%h exp=0,0,0,0", word_valid_m, fifo_count_m, busy_m, word_data_m);
      end
      frame_active = 1'b0;
      tick();
      #2;
      rstnn = 1'b1;
      qm.delete();
      ql.delete();
      exp_ovf = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int lm, l, n, k, ulen, nxt;
      bit upd;
      word_ready = 1'b1;
      for (int f = 0; f < 15; f++) begin
         lm = $urandom_range(0, 3);
         l = lanes_of(lm);
         n = 8 / l;
         k = $urandom_range(1, 3);
         for (int j = 0; j <= k; j++) begin
            upd = (j < k) ? 1'($urandom_range(0, 1)) : 1'b0;
            ulen = $urandom_range(0, 40);
            send_word(lm, n, rand_word(n * l), upd, 8'(ulen));
            if (upd) begin
               nxt = (ulen > 32 / l - 1) ? 32 / l - 1 : ulen;
               n = nxt + 1;
            end
         end
         frame_active = 1'b0;
         tick();
         total++;
         if (partial_drop_m !== 1'b0 || word_valid_m !== 1'b0) begin
            bad++;
            $display("FAIL rand_frame_end f=%0d got=%b,%b exp=0,0", f, partial_drop_m, word_valid_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_lane();
      test_quad();
      test_lsb_dual();
      test_partial();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
